spart_rx: RTL and testbench

Receive stage of the SPART, directly downstream of the baud generator. Consumes the generator's 16x-oversampling enable pulse (issued once per down-counter expiry). Deserialises the asynchronous rxd line (8N1, LSB first) into a byte for the bus interface. Flags data-available, framing error and overrun.

---
 rtl/spart_rx.sv | 116 +++++++++++
 tb/tb_spart_rx.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/spart_rx.sv
// SPART receiver: 8N1 deserialiser driven by the baud generator's oversampling enable.
// Produces rx_data with data-available, framing-error and overrun flags.
module spart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_en,
  input  logic                 rxd,
  input  logic                 clr_rda,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_q, state_d;
  logic                 rxd_meta_q, rxd_s_q;
  logic                 prev_q, prev_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rda_q, rda_d;
  logic                 fe_q, fe_d;
  logic                 ov_q, ov_d;
  logic                 mid_hit, end_hit, done;

  assign mid_hit = baud_en && (tick_q == TICK_MID);
  assign end_hit = baud_en && (tick_q == TICK_END);
  assign done    = (state_q == STOP) && end_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      prev_q     <= 1'b1;
      state_q    <= IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rda_q      <= 1'b0;
      fe_q       <= 1'b0;
      ov_q       <= 1'b0;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
      prev_q     <= prev_d;
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rda_q      <= rda_d;
      fe_q       <= fe_d;
      ov_q       <= ov_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (baud_en && prev_q && !rxd_s_q) state_d = START;
      START:   if (mid_hit) state_d = rxd_s_q ? IDLE : DATA;
      DATA:    if (end_hit && (bit_q == BIT_LAST)) state_d = STOP;
      STOP:    if (end_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    // Tick restarts on every state entry so each state measures from its own start.
    if (state_q == IDLE || state_d != state_q) tick_d = '0;
    else if (baud_en)                          tick_d = tick_q + TW'(1);
    else                                       tick_d = tick_q;

    prev_d = prev_q;
    if ((state_q == IDLE && baud_en) || done) prev_d = rxd_s_q;

    bit_d   = bit_q;
    shift_d = shift_q;
    if (state_q == START && state_d == DATA) bit_d = '0;
    if (state_q == DATA && end_hit) begin
      bit_d   = bit_q + BW'(1);
      shift_d = {rxd_s_q, shift_q[DATA_BITS-1:1]};
    end

    rx_data_d = rx_data_q;
    fe_d      = fe_q;
    rda_d     = rda_q & ~clr_rda;
    ov_d      = ov_q & ~clr_rda;
    // A read in the completion cycle consumed the old byte, so it is not an overrun.
    if (done) begin
      rx_data_d = shift_q;
      rda_d     = 1'b1;
      fe_d      = ~rxd_s_q;
      ov_d      = rda_q & ~clr_rda;
    end
  end

  assign rx_data   = rx_data_q;
  assign rda       = rda_q;
  assign frame_err = fe_q;
  assign overrun   = ov_q;

endmodule

// File: tb/tb_spart_rx.sv
// Directed bench for spart_rx: frames are driven one baud unit (4 clks) at a time and
// expected completions are queued; a negedge monitor pops and checks them.
module tb_spart_rx;

  logic       clk = 1'b0;
  logic       rst, baud_en, rxd, clr_rda;
  logic [7:0] rx_data;
  logic       rda, frame_err, overrun;

  typedef struct {
    logic [7:0] data;
    logic       fe;
    logic       ov;
    longint     due;
  } exp_t;

  exp_t   sb[$];
  longint cyc = 0;
  int     checks = 0;
  int     errors = 0;

  spart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_en   (baud_en),
    .rxd       (rxd),
    .clr_rda   (clr_rda),
    .rx_data   (rx_data),
    .rda       (rda),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // One baud unit: rxd set, baud_en pulses on the 4th clock of the unit.
  task automatic unit(input logic v, input logic clr_on_pulse);
    rxd     = v;
    baud_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    baud_en = 1'b1;
    clr_rda = clr_on_pulse;
    @(posedge clk);
    #1;
    baud_en = 1'b0;
    clr_rda = 1'b0;
  endtask

  task automatic units(input logic v, input int n);
    for (int i = 0; i < n; i++) unit(v, 1'b0);
  endtask

  // Completion lands on the pulse of unit 152, i.e. the 612th clock edge after entry.
  task automatic send_frame(input logic [7:0] d, input logic stop_v,
                            input logic exp_fe, input logic exp_ov, input logic clr_done);
    exp_t   e;
    logic   v;
    e.data = d;
    e.fe   = exp_fe;
    e.ov   = exp_ov;
    e.due  = cyc + 612;
    sb.push_back(e);
    for (int k = 0; k < 160; k++) begin
      if (k < 16)       v = 1'b0;
      else if (k < 144) v = d[(k - 16) / 16];
      else              v = stop_v;
      unit(v, clr_done && (k == 152));
    end
  endtask

  task automatic pulse_clr();
    clr_rda = 1'b1;
    @(posedge clk);
    #1;
    clr_rda = 1'b0;
  endtask

  // Monitor: a completion shows up as rda rising, overrun rising, or new data while rda is set.
  logic       rda_p = 1'b0, ov_p = 1'b0;
  logic [7:0] data_p = 8'h00;
  exp_t       got;
  always @(negedge clk) begin
    if ((rda === 1'b1 && rda_p !== 1'b1) || (overrun === 1'b1 && ov_p !== 1'b1) ||
        (rda === 1'b1 && rx_data !== data_p)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got byte 0x%02h rda=%b, required no completion",
                 rx_data, rda);
      end else begin
        got = sb.pop_front();
        $display("rx byte 0x%02h fe=%b ov=%b at cycle %0d", rx_data, frame_err, overrun, cyc);
        chk("rx_data", rx_data, got.data);
        chk("rda", rda, 1);
        chk("frame_err", frame_err, got.fe);
        chk("overrun", overrun, got.ov);
        chk("latency_cycle", cyc, got.due);
      end
    end
    rda_p  = rda;
    ov_p   = overrun;
    data_p = rx_data;
  end

  task automatic check_cleared(input string tag);
    chk({tag, "_rx_data"}, rx_data, 0);
    chk({tag, "_rda"}, rda, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  initial begin
    // Reset with baud_en high and line low: reset must dominate.
    rst = 1'b1; baud_en = 1'b1; rxd = 1'b0; clr_rda = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    rst = 1'b0; baud_en = 1'b0; rxd = 1'b1;
    units(1'b1, 32);
    chk("idle_rda", rda, 0);

    // Nominal byte, then read.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_clr();
    chk("clr_rda", rda, 0);
    chk("clr_overrun", overrun, 0);

    // Start-bit glitch is rejected, the following frame is received.
    units(1'b0, 3);
    units(1'b1, 20);
    chk("glitch_rda", rda, 0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_clr();

    // Framing error followed by a held-low line (break).
    send_frame(8'h81, 1'b0, 1'b1, 1'b0, 1'b0);
    units(1'b0, 40);
    chk("break_rx_data", rx_data, 8'h81);
    chk("break_rda", rda, 1);
    pulse_clr();
    chk("fe_held_after_clr", frame_err, 1);
    units(1'b1, 20);
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);

    // Overrun, then read clears it.
    pulse_clr();
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b1, 1'b0);
    pulse_clr();
    chk("ovr_clr_overrun", overrun, 0);
    chk("ovr_clr_rda", rda, 0);

    // Read in the completion cycle: completion wins, no overrun.
    send_frame(8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h44, 1'b1, 1'b0, 1'b0, 1'b1);

    // Reset during bit 4 of 0xF0 aborts the frame.
    units(1'b0, 16);
    for (int b = 0; b < 4; b++) units(b >= 4, 16);
    units(1'b1, 8);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("midrst");
    rst = 1'b0;
    units(1'b1, 20);
    send_frame(8'h0F, 1'b1, 1'b0, 1'b0, 1'b0);

    units(1'b1, 10);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
